mult_div_32: RTL and testbench

- Iterative 32-bit integer multiply/divide unit beside the main ALU (MIPS-style MULT/MULTU/DIV/DIVU).
- Accepts one operation at a time and writes a 64-bit result as HI/LO.
- Busy flags let the pipeline stall dependent instructions.
- Write strobes tell the HI/LO file when a result is valid.

---
 rtl/mult_div_32.sv | 162 ++++++++++++++++
 tb/tb_mult_div_32.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_32.sv
// Iterative 32-bit multiply/divide unit producing a 64-bit HI/LO result.
// Multiply retires in 2 busy cycles; restoring divide retires 4 bits/cycle in 9 busy cycles.
module mult_div_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        md,
  input  logic [1:0]  ALU_OP,
  input  logic [31:0] ALU_A,
  input  logic [31:0] ALU_B,
  output logic [31:0] ALU_HI,
  output logic [31:0] ALU_LO,
  output logic        MULTBUSY,
  output logic        DIVBUSY,
  output logic        MULTWRITE,
  output logic        DIVWRITE
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q;
  logic        signed_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [63:0] prod_q;

  logic        start_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod_full;
  logic [32:0] step_r;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Magnitudes taken from the live inputs so they can be latched on the start edge.
  always_comb begin
    start_signed = ~ALU_OP[0];
    mag_a        = (start_signed && ALU_A[31]) ? (~ALU_A + 32'd1) : ALU_A;
    mag_b        = (start_signed && ALU_B[31]) ? (~ALU_B + 32'd1) : ALU_B;
  end

  always_comb begin
    ext_a     = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b     = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_full = ext_a * ext_b;
  end

  // Four restoring-division steps; the dividend shifts out of quo_q as quotient bits shift in.
  always_comb begin
    step_r   = 33'd0;
    rem_step = rem_q;
    quo_step = quo_q;
    for (int i = 0; i < 4; i++) begin
      step_r   = {rem_step, quo_step[31]};
      quo_step = {quo_step[30:0], 1'b0};
      if (step_r >= {1'b0, dvs_q}) begin
        step_r      = step_r - {1'b0, dvs_q};
        quo_step[0] = 1'b1;
      end
      rem_step = step_r[31:0];
    end
  end

  always_comb begin
    quo_fix = qneg_q ? (~quo_q + 32'd1) : quo_q;
    rem_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      signed_q  <= 1'b0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      cnt_q     <= 4'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      prod_q    <= 64'd0;
      ALU_HI    <= 32'd0;
      ALU_LO    <= 32'd0;
      MULTBUSY  <= 1'b0;
      DIVBUSY   <= 1'b0;
      MULTWRITE <= 1'b0;
      DIVWRITE  <= 1'b0;
    end else begin
      MULTWRITE <= 1'b0;
      DIVWRITE  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (md) begin
            a_q      <= ALU_A;
            b_q      <= ALU_B;
            signed_q <= start_signed;
            cnt_q    <= 4'd0;
            if (ALU_OP[1]) begin
              state_q <= StDiv;
              DIVBUSY <= 1'b1;
              quo_q   <= mag_a;
              dvs_q   <= mag_b;
              rem_q   <= 32'd0;
              qneg_q  <= start_signed & (ALU_A[31] ^ ALU_B[31]);
              rneg_q  <= start_signed & ALU_A[31];
            end else begin
              state_q  <= StMul;
              MULTBUSY <= 1'b1;
            end
          end
        end
        StMul: begin
          if (cnt_q == 4'd0) begin
            prod_q <= prod_full;
            cnt_q  <= 4'd1;
          end else begin
            ALU_HI    <= prod_q[63:32];
            ALU_LO    <= prod_q[31:0];
            MULTBUSY  <= 1'b0;
            MULTWRITE <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDiv: begin
          if (cnt_q != 4'd8) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q + 4'd1;
          end else begin
            // Divide by zero reports all-ones quotient and the raw dividend.
            if (dvs_q == 32'd0) begin
              ALU_LO <= 32'hFFFF_FFFF;
              ALU_HI <= a_q;
            end else begin
              ALU_LO <= quo_fix;
              ALU_HI <= rem_fix;
            end
            DIVBUSY  <= 1'b0;
            DIVWRITE <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_32.sv
// Randomised self-checking bench for mult_div_32 against an arithmetic reference model.
module tb_mult_div_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        md;
  logic [1:0]  ALU_OP;
  logic [31:0] ALU_A;
  logic [31:0] ALU_B;
  logic [31:0] ALU_HI;
  logic [31:0] ALU_LO;
  logic        MULTBUSY;
  logic        DIVBUSY;
  logic        MULTWRITE;
  logic        DIVWRITE;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_32 dut (
    .clk       (clk),
    .rst       (rst),
    .md        (md),
    .ALU_OP    (ALU_OP),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_HI    (ALU_HI),
    .ALU_LO    (ALU_LO),
    .MULTBUSY  (MULTBUSY),
    .DIVBUSY   (DIVBUSY),
    .MULTWRITE (MULTWRITE),
    .DIVWRITE  (DIVWRITE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo);
    longint          p;
    longint unsigned pu;
    int              q;
    int              r;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      2'b00: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32];
        lo = pu[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          q  = $signed(a) / $signed(b);
          r  = $signed(a) % $signed(b);
          lo = q;
          hi = r;
        end
      end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          busy_cycles;
    logic        got_write;
    ref_model(op, a, b, exp_hi, exp_lo);
    @(negedge clk);
    ALU_OP = op;
    ALU_A  = a;
    ALU_B  = b;
    md     = 1'b1;
    @(posedge clk);
    #1;
    md     = 1'b0;
    // Scramble inputs after the start edge; the unit must ignore them.
    ALU_OP = 2'($urandom);
    ALU_A  = $urandom;
    ALU_B  = $urandom;
    busy_cycles = 0;
    got_write   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (MULTWRITE || DIVWRITE) begin
        got_write = 1'b1;
        break;
      end
      if (op[1] ? DIVBUSY : MULTBUSY) busy_cycles++;
    end
    check($sformatf("%s write_seen", name), 64'(got_write), 64'd1);
    check($sformatf("%s busy_cycles", name), 64'(busy_cycles), op[1] ? 64'd9 : 64'd2);
    check($sformatf("%s write_kind", name), {62'd0, MULTWRITE, DIVWRITE},
          op[1] ? 64'd1 : 64'd2);
    check($sformatf("%s busy_at_write", name), {62'd0, MULTBUSY, DIVBUSY}, 64'd0);
    check($sformatf("%s result", name), {ALU_HI, ALU_LO}, {exp_hi, exp_lo});
    @(negedge clk);
    check($sformatf("%s pulse_end", name), {62'd0, MULTWRITE, DIVWRITE}, 64'd0);
    check($sformatf("%s hold", name), {ALU_HI, ALU_LO}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        saw_write;

    rst    = 1'b1;
    md     = 1'b0;
    ALU_OP = 2'b00;
    ALU_A  = 32'd0;
    ALU_B  = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {ALU_HI, ALU_LO}, 64'd0);
    check("reset_flags", {60'd0, MULTBUSY, DIVBUSY, MULTWRITE, DIVWRITE}, 64'd0);
    rst = 1'b0;

    // Idle with md low: nothing happens.
    repeat (3) @(negedge clk);
    check("idle_flags", {60'd0, MULTBUSY, DIVBUSY, MULTWRITE, DIVWRITE}, 64'd0);

    run_op(2'b01, 32'd4, 32'd5, "multu_4x5");
    run_op(2'b00, 32'hFFFF_FFFC, 32'd5, "mult_m4x5");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b11, 32'd7, 32'd2, "divu_7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    run_op(2'b10, 32'd5, 32'd0, "div_5_0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big");
    run_op(2'b11, 32'h9000_0000, 32'd0, "divu_by0");

    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, a, b, $sformatf("rand%0d_op%0d", n, op));
    end

    // Leave a nonzero result, then abort a divide in its 4th busy cycle.
    run_op(2'b11, 32'd7, 32'd2, "pre_abort");
    @(negedge clk);
    ALU_OP = 2'b10;
    ALU_A  = 32'd1000;
    ALU_B  = 32'd7;
    md     = 1'b1;
    @(posedge clk);
    #1;
    md = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", {ALU_HI, ALU_LO}, 64'd0);
    check("abort_flags", {60'd0, MULTBUSY, DIVBUSY, MULTWRITE, DIVWRITE}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_write = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (MULTWRITE || DIVWRITE || DIVBUSY) saw_write = 1'b1;
    end
    check("abort_no_write", 64'(saw_write), 64'd0);
    run_op(2'b01, 32'd3, 32'd3, "multu_3x3_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
